// File: rtl/mod_n_updown_counter_if.sv
// Control and status bundle for mod_n_updown_counter.
// The master drives the controls and the counter (slave) returns its registered state.
interface mod_n_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             load;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] dout;
    logic             tc;
    logic             dir;
    logic             done;

    modport master (
        output clr, load, en, mode, data_in,
        input  dout, tc, dir, done
    );

    modport slave (
        input  clr, load, en, mode, data_in,
        output dout, tc, dir, done
    );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Modulo-N loadable counter with up-wrap, down-wrap, ping-pong and one-shot modes.
// Every output is a register; tc is a one-cycle pulse, so cascading is tc -> en of the next stage.
module mod_n_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12
) (
    input logic                   clk,
    input logic                   rstn,
    mod_n_updown_counter_if.slave bus
);
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_ONCE = 2'b11;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] BELOW    = WIDTH'(MODULUS - 2);
    // One extra bit so MODULUS = 2**WIDTH still compares correctly against data_in.
    localparam logic [WIDTH:0]   MOD_WIDE = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] count_reg, count_next;
    logic             dir_reg, dir_next;
    logic             done_reg, done_next;
    logic             tc_reg, tc_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
            dir_reg   <= 1'b0;
            done_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            dir_reg   <= dir_next;
            done_reg  <= done_next;
            tc_reg    <= tc_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        dir_next   = dir_reg;
        done_next  = done_reg;
        tc_next    = 1'b0;

        if (bus.clr) begin
            count_next = '0;
            dir_next   = 1'b0;
            done_next  = 1'b0;
        end else if (bus.load) begin
            count_next = ({1'b0, bus.data_in} < MOD_WIDE) ? bus.data_in : TOP;
            dir_next   = (bus.mode == MODE_DOWN);
            done_next  = 1'b0;
        end else begin
            // The sticky done flag only survives while the counter stays in one-shot mode.
            if (bus.mode != MODE_ONCE) begin
                done_next = 1'b0;
            end
            if (bus.en) begin
                unique case (bus.mode)
                    MODE_UP: begin
                        dir_next = 1'b0;
                        if (count_reg == TOP) begin
                            count_next = '0;
                            tc_next    = 1'b1;
                        end else begin
                            count_next = count_reg + ONE;
                        end
                    end
                    MODE_DOWN: begin
                        dir_next = 1'b1;
                        if (count_reg == '0) begin
                            count_next = TOP;
                            tc_next    = 1'b1;
                        end else begin
                            count_next = count_reg - ONE;
                        end
                    end
                    MODE_PING: begin
                        // Endpoints turn around immediately so each is held for a single cycle.
                        if (!dir_reg && count_reg == TOP) begin
                            dir_next   = 1'b1;
                            count_next = BELOW;
                            tc_next    = 1'b1;
                        end else if (dir_reg && count_reg == '0) begin
                            dir_next   = 1'b0;
                            count_next = ONE;
                            tc_next    = 1'b1;
                        end else if (dir_reg) begin
                            count_next = count_reg - ONE;
                        end else begin
                            count_next = count_reg + ONE;
                        end
                    end
                    MODE_ONCE: begin
                        dir_next = 1'b0;
                        if (!done_reg) begin
                            if (count_reg == TOP) begin
                                done_next = 1'b1;
                                tc_next   = 1'b1;
                            end else begin
                                count_next = count_reg + ONE;
                            end
                        end
                    end
                    default: begin
                        count_next = count_reg;
                    end
                endcase
            end
        end
    end

    assign bus.dout = count_reg;
    assign bus.tc   = tc_reg;
    assign bus.dir  = dir_reg;
    assign bus.done = done_reg;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Randomised bench for mod_n_updown_counter checked against an integer reference model,
// with short directed runs through the mode, load-clamp, priority and async-reset cases.
module tb_mod_n_updown_counter;
    localparam int WIDTH   = 4;
    localparam int MODULUS = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    mod_n_updown_counter_if #(.WIDTH(WIDTH)) bus ();

    mod_n_updown_counter #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_step = 0;

    // Reference state as plain integers.
    int m_count = 0;
    int m_dir   = 0;
    int m_done  = 0;
    int m_tc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (step %0d)", tag, got, exp, n_step);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_dir   = 0;
        m_done  = 0;
        m_tc    = 0;
    endtask

    task automatic model_edge(input int c, input int l, input int e, input int m, input int d);
        m_tc = 0;
        if (c != 0) begin
            m_count = 0;
            m_dir   = 0;
            m_done  = 0;
        end else if (l != 0) begin
            m_count = (d < MODULUS) ? d : MODULUS - 1;
            m_dir   = (m == 1) ? 1 : 0;
            m_done  = 0;
        end else begin
            if (m != 3) m_done = 0;
            if (e != 0) begin
                case (m)
                    0: begin
                        m_dir   = 0;
                        m_tc    = (m_count == MODULUS - 1) ? 1 : 0;
                        m_count = (m_count + 1) % MODULUS;
                    end
                    1: begin
                        m_dir   = 1;
                        m_tc    = (m_count == 0) ? 1 : 0;
                        m_count = (m_count + MODULUS - 1) % MODULUS;
                    end
                    2: begin
                        if (m_dir == 0 && m_count == MODULUS - 1) m_dir = 1;
                        else if (m_dir == 1 && m_count == 0) m_dir = 0;
                        else m_tc = -1;
                        m_tc    = (m_tc == 0) ? 1 : 0;
                        m_count = m_count + ((m_dir == 0) ? 1 : -1);
                    end
                    default: begin
                        m_dir = 0;
                        if (m_done == 0) begin
                            if (m_count == MODULUS - 1) begin
                                m_done = 1;
                                m_tc   = 1;
                            end else begin
                                m_count = m_count + 1;
                            end
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".dout"}, 32'(bus.dout), 32'(m_count));
        check({where, ".tc"},   32'(bus.tc),   32'(m_tc));
        check({where, ".dir"},  32'(bus.dir),  32'(m_dir));
        check({where, ".done"}, 32'(bus.done), 32'(m_done));
    endtask

    // Called just after a falling edge: drive, let one rising edge happen, check at the next fall.
    task automatic step(input logic c, input logic l, input logic e,
                        input logic [1:0] m, input logic [WIDTH-1:0] d);
        bus.clr     = c;
        bus.load    = l;
        bus.en      = e;
        bus.mode    = m;
        bus.data_in = d;
        model_edge(int'(c), int'(l), int'(e), int'(m), int'(d));
        @(negedge clk);
        n_step++;
        compare_all("step");
        $display("step %0d clr=%0b load=%0b en=%0b mode=%0d din=%0d -> dout=%0d tc=%0b dir=%0b done=%0b",
                 n_step, c, l, e, m, d, bus.dout, bus.tc, bus.dir, bus.done);
    endtask

    task automatic async_reset_pulse();
        #2 rstn = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
        rstn = 1'b1;
    endtask

    initial begin
        logic [1:0] r_mode;
        bus.clr     = 1'b0;
        bus.load    = 1'b0;
        bus.en      = 1'b0;
        bus.mode    = 2'b00;
        bus.data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("reset");
        rstn = 1'b1;

        // Up-wrap through the terminal count.
        for (int i = 0; i < 13; i++) step(0, 0, 1, 2'b00, 0);
        // Load clamp, then down-wrap.
        step(0, 1, 0, 2'b01, 4'd14);
        check("clamp", 32'(bus.dout), 32'(MODULUS - 1));
        for (int i = 0; i < 13; i++) step(0, 0, 1, 2'b01, 0);
        // Ping-pong round trip.
        step(0, 1, 0, 2'b10, 0);
        for (int i = 0; i < 24; i++) step(0, 0, 1, 2'b10, 0);
        // One-shot, sticky done, then load clears it.
        step(0, 1, 0, 2'b11, 4'd9);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 2'b11, 0);
        check("oneshot_done", 32'(bus.done), 32'd1);
        step(0, 1, 1, 2'b11, 4'd3);
        // Priority and enable.
        step(1, 1, 1, 2'b00, 4'd5);
        step(0, 1, 1, 2'b00, 4'd5);
        step(0, 0, 0, 2'b00, 4'd2);
        step(0, 0, 0, 2'b00, 4'd2);
        // Async reset while counting down in ping-pong at 7.
        step(0, 1, 0, 2'b01, 4'd8);
        step(0, 0, 1, 2'b10, 0);
        check("pre_rst_dout", 32'(bus.dout), 32'd7);
        check("pre_rst_dir", 32'(bus.dir), 32'd1);
        async_reset_pulse();
        step(0, 0, 1, 2'b00, 0);
        check("post_rst_dout", 32'(bus.dout), 32'd1);

        // Randomised traffic; mode is held for runs so counts reach their endpoints.
        r_mode = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) r_mode = 2'($urandom_range(3));
            if ($urandom_range(199) == 0) async_reset_pulse();
            step(($urandom_range(31) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
                 r_mode, WIDTH'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
